// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two channels
//
// Purpose:
//   Two requesters (ch0, ch1) issue ALU operations through valid/ready request
//   ports and get results back on valid/ready response ports. The arbiter runs
//   one operation at a time through IDLE -> EXEC -> RESP. When both channels
//   request together, the channel that was not granted last wins.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req_valid0/1         request valid per channel
//   req_ready0/1         request accepted when valid & ready (IDLE only)
//   req_a0/1, req_b0/1   operands per channel
//   req_op0/1            ALUOp per channel
//   rsp_valid0/1         result valid for the channel that issued it
//   rsp_ready0/1         channel consumes its result
//   rsp_c                registered result (shared bus, qualify with rsp_validN)
//   rsp_err              illegal-op flag (shared, qualify with rsp_validN)
//   alu_a, alu_b, alu_op operands and opcode driven to the external ALU
//   alu_c                result from the external ALU
//
// Build option:
//   ALU_ARB_ILLEGAL_OP_EN - ops 110/111 drive alu_op=000 and return rsp_c=0
//   with rsp_err=1. When undefined, ops pass through and rsp_err is tied 0.

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [OPW-1:0]   req_op0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op1,
  output logic             rsp_valid0,
  input  logic             rsp_ready0,
  output logic             rsp_valid1,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             last_gnt;   // channel granted most recently
  logic             cur_ch;     // channel owning the operation in flight
  logic             gnt_any;
  logic             gnt_ch;
  logic             hs;
  logic             rsp_take;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  // Grant is purely combinational on the current valids. With no valid the
  // value of gnt_ch is irrelevant because gnt_any gates every use of it.
  always_comb begin
    gnt_any = req_valid0 | req_valid1;
    if (req_valid0 && req_valid1) begin
      gnt_ch = ~last_gnt;
    end else begin
      gnt_ch = ~req_valid0;
    end
  end

  assign sel_a  = gnt_ch ? req_a1  : req_a0;
  assign sel_b  = gnt_ch ? req_b1  : req_b0;
  assign sel_op = gnt_ch ? req_op1 : req_op0;

  // A request offered during the reset cycle is not accepted, so ready is
  // suppressed rather than letting the requester see a dropped handshake.
  assign hs       = (state == IDLE) && gnt_any && !reset;
  assign rsp_take = cur_ch ? rsp_ready1 : rsp_ready0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; a response caught by reset is never presented.
  always_comb begin
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    if (hs) begin
      req_ready0 = ~gnt_ch;
      req_ready1 = gnt_ch;
    end
    if ((state == RESP) && !reset) begin
      rsp_valid0 = ~cur_ch;
      rsp_valid1 = cur_ch;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic sel_illegal;
  logic illegal_q;
  logic rsp_err_q;

  assign sel_illegal = (sel_op == OPW'(6)) || (sel_op == OPW'(7));
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // The latched request registers drive the ALU directly: they only change
  // on the handshake edge, so the ALU inputs move exactly when EXEC begins
  // and hold their values everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      cur_ch    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_c     <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      illegal_q <= 1'b0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      if (hs) begin
        last_gnt <= gnt_ch;
        cur_ch   <= gnt_ch;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
`ifdef ALU_ARB_ILLEGAL_OP_EN
        alu_op    <= sel_illegal ? '0 : sel_op;
        illegal_q <= sel_illegal;
`else
        alu_op   <= sel_op;
`endif
      end
      if (state == EXEC) begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
        rsp_c     <= illegal_q ? '0 : alu_c;
        rsp_err_q <= illegal_q;
`else
        rsp_c <= alu_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a transaction-level model

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] rsp_c;
  logic        rsp_err;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: also serves as the external ALU attached to the DUT.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a >> sh;
      3'd5:    return $signed(a) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_c = alu_ref(alu_a, alu_b, alu_op);

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_ready0(req_ready0),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_valid1(req_valid1), .req_ready1(req_ready1),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid0(rsp_valid0), .rsp_ready0(rsp_ready0),
    .rsp_valid1(rsp_valid1), .rsp_ready1(rsp_ready1),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

`ifdef ALU_ARB_ILLEGAL_OP_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif

  // Transaction-level model: one outstanding operation, identified by the
  // cycle of its handshake; its response is due two cycles later.
  int          cyc_n   = 0;
  bit          m_busy  = 1'b0;
  int          m_hs    = 0;
  int          m_ch    = 0;
  int          m_last  = 1;
  logic [31:0] m_res   = '0;
  logic        m_err   = 1'b0;
  logic [31:0] m_alu_a = '0;
  logic [31:0] m_alu_b = '0;
  logic [2:0]  m_alu_op = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc_n, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_busy || reset) return -1;
    if (req_valid0 && req_valid1) return 1 - m_last;
    if (req_valid0) return 0;
    if (req_valid1) return 1;
    return -1;
  endfunction

  task automatic check();
    int g;
    bit rv;
    g  = model_grant();
    rv = m_busy && !reset && (cyc_n >= m_hs + 2);
    chk("req_ready0", req_ready0, g == 0);
    chk("req_ready1", req_ready1, g == 1);
    chk("rsp_valid0", rsp_valid0, rv && m_ch == 0);
    chk("rsp_valid1", rsp_valid1, rv && m_ch == 1);
    if (rv) begin
      chk("rsp_c", rsp_c, m_res);
      chk("rsp_err", rsp_err, m_err);
    end
    chk("alu_a", alu_a, m_alu_a);
    chk("alu_b", alu_b, m_alu_b);
    chk("alu_op", alu_op, m_alu_op);
  endtask

  task automatic update();
    int g;
    logic [31:0] a, b;
    logic [2:0] op;
    g = model_grant();
    if (reset) begin
      m_busy = 1'b0; m_last = 1;
      m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
    end else if (m_busy) begin
      if (cyc_n >= m_hs + 2 && (m_ch == 1 ? rsp_ready1 : rsp_ready0)) m_busy = 1'b0;
    end else if (g >= 0) begin
      a  = (g == 1) ? req_a1 : req_a0;
      b  = (g == 1) ? req_b1 : req_b0;
      op = (g == 1) ? req_op1 : req_op0;
      m_busy = 1'b1; m_hs = cyc_n; m_ch = g; m_last = g;
      m_alu_a = a; m_alu_b = b; m_alu_op = op;
      m_res = alu_ref(a, b, op); m_err = 1'b0;
      if (ILLEGAL_EN && op >= 3'd6) begin
        m_alu_op = 3'd0; m_res = 32'd0; m_err = 1'b1;
      end
    end
    cyc_n++;
  endtask

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cyc();
    #2;
    check();
    update();
    @(posedge clk);
    #1;
  endtask

  int obs_ch[8];
  int obs_cy[8];
  int nobs;

  initial begin
    reset = 1'b1;
    req_valid0 = 0; req_valid1 = 0;
    req_a0 = 0; req_b0 = 0; req_op0 = 0;
    req_a1 = 0; req_b1 = 0; req_op1 = 0;
    rsp_ready0 = 1; rsp_ready1 = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    // reset state
    chk("rst_rsp_valid0", rsp_valid0, 0);
    chk("rst_rsp_valid1", rsp_valid1, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_req_ready0", req_ready0, 0);

    // 1: ch0 alone, 5+3
    req_valid0 = 1; req_a0 = 5; req_b0 = 3; req_op0 = 0;
    cyc();
    req_valid0 = 0;
    cyc();
    chk("t1_rsp_valid0", rsp_valid0, 1);
    chk("t1_rsp_c", rsp_c, 32'd8);
    chk("t1_rsp_valid1", rsp_valid1, 0);
    cyc();

    // 2: both valid right after reset, ch0 first
    reset = 1; cyc(); reset = 0;
    req_valid0 = 1; req_a0 = 1; req_b0 = 1; req_op0 = 3'b001;
    req_valid1 = 1; req_a1 = 32'hF0; req_b1 = 32'h0F; req_op1 = 3'b011;
    cyc();
    req_valid0 = 0;
    cyc();
    chk("t2_rsp_valid0", rsp_valid0, 1);
    chk("t2_rsp_c0", rsp_c, 32'd0);
    cyc();
    cyc();
    req_valid1 = 0;
    cyc();
    chk("t2_rsp_valid1", rsp_valid1, 1);
    chk("t2_rsp_c1", rsp_c, 32'hFF);
    cyc();

    // 3: both valid continuously, grants alternate 3 cycles apart
    nobs = 0;
    req_valid0 = 1; req_valid1 = 1;
    for (int i = 0; i < 12; i++) begin
      req_a0 = $urandom; req_b0 = $urandom; req_op0 = 3'($urandom_range(0, 5));
      req_a1 = $urandom; req_b1 = $urandom; req_op1 = 3'($urandom_range(0, 5));
      cyc();
      if ((rsp_valid0 || rsp_valid1) && nobs < 8) begin
        obs_ch[nobs] = rsp_valid1 ? 1 : 0;
        obs_cy[nobs] = cyc_n;
        nobs++;
      end
    end
    chk("t3_count", nobs, 4);
    for (int i = 0; i < 4; i++)
      if (i < nobs) chk("t3_grant_order", obs_ch[i], i % 2);
    for (int i = 1; i < 4; i++)
      if (i < nobs) chk("t3_spacing", obs_cy[i] - obs_cy[i-1], 3);
    req_valid0 = 0; req_valid1 = 0;

    // 4: ch1 sra held under backpressure while ch0 waits
    req_valid1 = 1; req_a1 = 32'h8000_0000; req_b1 = 4; req_op1 = 3'b101;
    rsp_ready1 = 0;
    cyc();
    req_valid1 = 0;
    req_valid0 = 1; req_a0 = $urandom; req_b0 = $urandom; req_op0 = 3'd2;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t4_rsp_valid1", rsp_valid1, 1);
      chk("t4_rsp_c", rsp_c, 32'hF800_0000);
      chk("t4_req_ready0", req_ready0, 0);
      cyc();
    end
    rsp_ready1 = 1;
    cyc();
    cyc();
    req_valid0 = 0;
    repeat (3) cyc();

    // 5: reset during EXEC discards the operation
    req_valid0 = 1; req_a0 = 9; req_b0 = 9; req_op0 = 0;
    cyc();
    req_valid0 = 0; reset = 1;
    cyc();
    reset = 0;
    chk("t5_rsp_valid0_a", rsp_valid0, 0);
    chk("t5_rsp_valid1_a", rsp_valid1, 0);
    cyc();
    chk("t5_rsp_valid0_b", rsp_valid0, 0);
    req_valid0 = 1; req_a0 = 10; req_b0 = 20; req_op0 = 0;
    cyc();
    req_valid0 = 0;
    cyc();
    chk("t5_rsp_valid0_c", rsp_valid0, 1);
    chk("t5_rsp_c", rsp_c, 32'd30);
    cyc();

    // 6: illegal op 111
    req_valid0 = 1; req_a0 = 7; req_b0 = 7; req_op0 = 3'b111;
    cyc();
    req_valid0 = 0;
    cyc();
    chk("t6_rsp_valid0", rsp_valid0, 1);
    chk("t6_rsp_c", rsp_c, 32'd0);
    chk("t6_rsp_err", rsp_err, ILLEGAL_EN ? 32'd1 : 32'd0);
    cyc();

    // Random traffic with backpressure and occasional reset
    for (int i = 0; i < 600; i++) begin
      req_valid0 = ($urandom_range(0, 99) < 60);
      req_valid1 = ($urandom_range(0, 99) < 60);
      req_a0 = $urandom; req_b0 = $urandom; req_op0 = 3'($urandom_range(0, 7));
      req_a1 = $urandom; req_b1 = $urandom; req_op1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        req_a0 = 32'($urandom_range(0, 255));
        req_b0 = 32'($urandom_range(0, 40));
      end
      rsp_ready0 = ($urandom_range(0, 99) < 70);
      rsp_ready1 = ($urandom_range(0, 99) < 70);
      reset = ($urandom_range(0, 99) < 2);
      cyc();
    end
    reset = 0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
